// File: rtl/binarize_thresh_ctrl.sv
// ----------------------------------------------------------------------------
// binarize_thresh_ctrl
// Threshold controller for a gray-to-binary stage. While a frame is active,
// every qualified pixel is summed and counted. At the frame end the sum and
// count go to a 12-step restoring divider, and accumulation of the next frame
// starts at once. The mean gray level, clamped to [MIN_TH, MAX_TH], becomes the
// new threshold. It is applied only while iFVAL is low, so a frame in flight
// never sees the threshold change.
//
// Ports
//   iCLK       clock, rising edge
//   iRST       asynchronous reset, active low
//   iFVAL      frame valid
//   iDVAL      pixel valid (qualifies iDATA while iFVAL=1)
//   iDATA      12-bit gray pixel
//   iMODE      0 = auto threshold, 1 = manual threshold
//   iMAN_TH    manual threshold value
//   oTHRESH    registered threshold
//   oTH_VALID  one-cycle pulse when an auto threshold is applied
//   oBUSY      division or pending update in progress
//   oDROP      sticky: a frame result was discarded (cleared by reset only)
// ----------------------------------------------------------------------------
module binarize_thresh_ctrl #(
    parameter logic [11:0] DEFAULT_TH = 12'd1047,
    parameter logic [11:0] MIN_TH     = 12'd256,
    parameter logic [11:0] MAX_TH     = 12'd3840,
    parameter int          CNT_W      = 21
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [11:0] iDATA,
    input  logic        iMODE,
    input  logic [11:0] iMAN_TH,
    output logic [11:0] oTHRESH,
    output logic        oTH_VALID,
    output logic        oBUSY,
    output logic        oDROP
);
    localparam int SUM_W = CNT_W + 12;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_PEND} state_t;

    state_t             state_q, state_d;
    logic               fval_q;
    logic               armed_q;    // iFVAL has been seen low since reset
    logic [SUM_W-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic [SUM_W-1:0]   rem_q;
    logic [SUM_W-1:0]   dvs_q;      // divisor, pre-shifted by the current bit position
    logic [11:0]        quo_q;
    logic [3:0]         it_q;
    logic [11:0]        res_q;
    logic [11:0]        th_q;
    logic               thv_q;
    logic               drop_q;

    logic               frame_end;
    logic               pix_ok;
    logic               cnt_full;
    logic               start;
    logic               load_th;
    logic               ge;
    logic [11:0]        quo_clamped;

    // Frame end counts only after an iFVAL low has been seen since reset. A
    // frame already running when reset is released is therefore ignored.
    assign frame_end = armed_q & fval_q & ~iFVAL;
    assign pix_ok    = armed_q & iFVAL & iDVAL;
    assign cnt_full  = (cnt_q == {CNT_W{1'b1}});
    assign start     = frame_end & (state_q == S_IDLE) & (cnt_q != '0) & ~ovf_q & ~iMODE;
    assign ge        = (rem_q >= dvs_q);

    always_comb begin
        quo_clamped = quo_q;
        if (quo_q < MIN_TH)      quo_clamped = MIN_TH;
        else if (quo_q > MAX_TH) quo_clamped = MAX_TH;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        load_th = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_DIV;
            S_DIV:  if (it_q == 4'd12) state_d = S_PEND;
            S_PEND: begin
                if (!iFVAL) begin
                    state_d = S_IDLE;
                    // In manual mode the result is silently discarded.
                    load_th = ~iMODE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Frame edge detection and pixel accumulation
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fval_q  <= 1'b0;
            armed_q <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            fval_q <= iFVAL;
            if (!iFVAL) armed_q <= 1'b1;
            if (frame_end) begin
                sum_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (pix_ok) begin
                if (cnt_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    sum_q <= sum_q + SUM_W'(iDATA);
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Restoring divider: one quotient bit per cycle, MSB first. The extra
    // cycle at it_q == 12 registers the clamped result on the way to PEND.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rem_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            it_q  <= '0;
            res_q <= '0;
        end else if (start) begin
            rem_q <= sum_q;
            dvs_q <= SUM_W'(cnt_q) << 11;
            quo_q <= '0;
            it_q  <= '0;
        end else if (state_q == S_DIV) begin
            if (it_q != 4'd12) begin
                if (ge) rem_q <= rem_q - dvs_q;
                quo_q <= {quo_q[10:0], ge};
                dvs_q <= dvs_q >> 1;
                it_q  <= it_q + 4'd1;
            end else begin
                res_q <= quo_clamped;
            end
        end
    end

    // Threshold output, valid pulse and drop flag
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            th_q   <= DEFAULT_TH;
            thv_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            if (iMODE)        th_q <= iMAN_TH;
            else if (load_th) th_q <= res_q;
            thv_q <= load_th;
            if (frame_end && state_q != S_IDLE) drop_q <= 1'b1;
        end
    end

    assign oTHRESH   = th_q;
    assign oTH_VALID = thv_q;
    assign oBUSY     = (state_q != S_IDLE);
    assign oDROP     = drop_q;
endmodule

// File: tb/tb_binarize_thresh_ctrl.sv
module tb_binarize_thresh_ctrl;
    logic        iCLK, iRST, iFVAL, iDVAL, iMODE;
    logic [11:0] iDATA, iMAN_TH;
    logic [11:0] oTHRESH;
    logic        oTH_VALID, oBUSY, oDROP;

    binarize_thresh_ctrl dut (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
        .iMODE(iMODE), .iMAN_TH(iMAN_TH), .oTHRESH(oTHRESH),
        .oTH_VALID(oTH_VALID), .oBUSY(oBUSY), .oDROP(oDROP)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] th;
        int          at_cyc;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int pix[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [11:0] model(input longint s, input int n);
        longint q;
        q = s / n;
        if (q < 256)       q = 256;
        else if (q > 3840) q = 3840;
        return 12'(q);
    endfunction

    // Drives one frame from pix[0..n-1] and leaves iFVAL low; the next edge is E.
    task automatic send_frame(input int n, input bit push);
        longint s;
        s = 0;
        iFVAL = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            iDVAL = 1'b1;
            iDATA = 12'(pix[i]);
            s += pix[i];
            tick();
        end
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        if (push) sb.push_back('{th: model(s, n), at_cyc: cyc + 15});
    endtask

    // Scoreboard side: every oTH_VALID pulse must match the oldest expectation.
    always @(negedge iCLK) begin
        if (iRST && oTH_VALID) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_thresh", 32'(oTHRESH), 32'(e.th));
                chk("sb_latency", cyc, e.at_cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0; iDATA = '0;
        iMODE = 1'b0; iMAN_TH = '0;

        // Reset
        repeat (3) tick();
        chk("rst_th", 32'(oTHRESH), 1047);
        chk("rst_flags", {oTH_VALID, oBUSY, oDROP}, 0);
        iRST = 1'b1;
        tick();
        chk("rel_th", 32'(oTHRESH), 1047);
        chk("rel_flags", {oTH_VALID, oBUSY, oDROP}, 0);

        // Auto frame with busy window
        pix[0] = 1000; pix[1] = 2000; pix[2] = 3000; pix[3] = 2000;
        send_frame(4, 1);
        tick();                               // after E
        tick();                               // after E+1
        chk("busy_e1", oBUSY, 1);
        repeat (12) tick();                   // after E+13
        chk("busy_e13", oBUSY, 1);
        chk("no_pulse_e13", oTH_VALID, 0);
        tick();                               // after E+14
        chk("busy_e14", oBUSY, 0);
        chk("auto_th", 32'(oTHRESH), 2000);
        repeat (6) tick();

        // Clamp low and high
        for (int i = 0; i < 3; i++) pix[i] = 100;
        send_frame(3, 1);
        repeat (20) tick();
        chk("clamp_lo", 32'(oTHRESH), 256);
        for (int i = 0; i < 5; i++) pix[i] = 4000;
        send_frame(5, 1);
        repeat (20) tick();
        chk("clamp_hi", 32'(oTHRESH), 3840);

        // Frame without pixels
        iFVAL = 1'b1;
        repeat (3) tick();
        iFVAL = 1'b0;
        tick();
        chk("empty_busy", oBUSY, 0);
        repeat (20) tick();
        chk("empty_th", 32'(oTHRESH), 3840);
        chk("empty_drop", oDROP, 0);

        // Manual mode
        iMODE = 1'b1; iMAN_TH = 12'd500;
        tick();
        chk("man_th", 32'(oTHRESH), 500);
        pix[0] = 3000; pix[1] = 3000;
        send_frame(2, 0);
        repeat (20) tick();
        chk("man_frame_busy", oBUSY, 0);
        iMODE = 1'b0;
        repeat (5) tick();
        chk("man_hold", 32'(oTHRESH), 500);
        send_frame(2, 1);
        repeat (20) tick();
        chk("man_next_auto", 32'(oTHRESH), 3000);

        // Manual selected while a division runs: result discarded, no drop
        pix[0] = 2500; pix[1] = 2500;
        send_frame(2, 0);
        tick();
        iMODE = 1'b1; iMAN_TH = 12'd777;
        repeat (20) tick();
        chk("man_div_th", 32'(oTHRESH), 777);
        chk("man_div_drop", oDROP, 0);
        iMODE = 1'b0;
        tick();

        // Random frames
        for (int f = 0; f < 4; f++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) pix[i] = $urandom_range(0, 4095);
            send_frame(n, 1);
            repeat (20) tick();
        end

        // Second frame end 5 cycles after the first
        pix[0] = 500; pix[1] = 700;
        send_frame(2, 1);
        tick();                               // after E
        chk("drop_pre", oDROP, 0);
        iFVAL = 1'b1;
        tick();
        iDVAL = 1'b1; iDATA = 12'd4000;
        tick();
        iDVAL = 1'b0;
        tick();
        tick();                               // after E+4
        iFVAL = 1'b0;
        tick();                               // after E+5
        chk("drop_set", oDROP, 1);
        chk("drop_busy", oBUSY, 1);
        repeat (20) tick();
        chk("drop_th", 32'(oTHRESH), 600);
        chk("drop_sticky", oDROP, 1);

        // Reset during division
        pix[0] = 1500;
        send_frame(1, 0);
        repeat (6) tick();
        iRST = 1'b0;
        #1;
        chk("midrst_th", 32'(oTHRESH), 1047);
        chk("midrst_flags", {oTH_VALID, oBUSY, oDROP}, 0);
        tick();
        iRST = 1'b1;
        repeat (20) tick();
        chk("midrst_after", 32'(oTHRESH), 1047);

        // Reset in the middle of a frame: that frame's end is ignored
        iFVAL = 1'b1;
        iDVAL = 1'b1; iDATA = 12'd3000;
        repeat (3) tick();
        iRST = 1'b0;
        tick();
        iRST = 1'b1;
        repeat (3) tick();
        iDVAL = 1'b0; iFVAL = 1'b0;
        tick();
        chk("partial_busy", oBUSY, 0);
        repeat (20) tick();
        chk("partial_th", 32'(oTHRESH), 1047);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
